// File: rtl/fpu_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract with flush-to-zero.
// Six-state FSM: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> IDLE, fixed 5-cycle latency.
// Optional feature: define FPU_ROUND_NEAREST_EN for round-to-nearest-even; the default build
// rounds toward zero and carries no rounding incrementer.
module fpu_addsub_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);

  typedef enum logic [2:0] {StIdle, StUnpack, StAlign, StAdd, StNorm, StRound} state_e;

  state_e state_q, state_d;

  logic [31:0] a_q, b_q;
  logic        op_q;
  logic        x_sign_q, y_sign_q;
  logic [7:0]  x_exp_q, y_exp_q;
  logic [22:0] x_man_q, y_man_q;
  logic        spec_q, spec_inv_q;
  logic [31:0] spec_res_q;
  logic [26:0] sx_q, sy_q;
  logic [27:0] sum_q;
  logic [26:0] nsig_q;
  logic signed [9:0] nexp_q;
  logic        done_q, ovf_q, unf_q, inv_q;
  logic [31:0] result_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state: one cycle per state, start only honoured in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StUnpack;
      StUnpack: state_d = StAlign;
      StAlign:  state_d = StAdd;
      StAdd:    state_d = StNorm;
      StNorm:   state_d = StRound;
      StRound:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Unpack: FTZ, classification, effective sign of B, magnitude swap
  logic [7:0]  ea, eb;
  logic [22:0] ma, mb;
  logic        sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
  logic        spec_d, spec_inv_d;
  logic [31:0] spec_res_d;
  always_comb begin
    ea    = a_q[30:23];
    eb    = b_q[30:23];
    ma    = (ea == 8'd0) ? 23'd0 : a_q[22:0];
    mb    = (eb == 8'd0) ? 23'd0 : b_q[22:0];
    sa    = a_q[31];
    sb    = b_q[31] ^ op_q;
    a_nan = (&ea) & (|ma);
    b_nan = (&eb) & (|mb);
    a_inf = (&ea) & ~(|ma);
    b_inf = (&eb) & ~(|mb);
    swap  = {eb, mb} > {ea, ma};
    spec_d     = 1'b0;
    spec_inv_d = 1'b0;
    spec_res_d = 32'd0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      spec_d     = 1'b1;
      spec_inv_d = 1'b1;
      spec_res_d = 32'h7FC00000;
    end else if (a_inf) begin
      spec_d     = 1'b1;
      spec_res_d = {sa, 8'hFF, 23'd0};
    end else if (b_inf) begin
      spec_d     = 1'b1;
      spec_res_d = {sb, 8'hFF, 23'd0};
    end
  end

  // Align: barrel shift Y right, folding every lost bit into sticky
  logic [26:0] sig_x, sig_y, lost, sy_d;
  logic [7:0]  diff;
  logic [4:0]  shamt;
  always_comb begin
    sig_x = {|x_exp_q, x_man_q, 3'b000};
    sig_y = {|y_exp_q, y_man_q, 3'b000};
    diff  = x_exp_q - y_exp_q;
    shamt = diff[4:0];
    lost  = sig_y & ((27'd1 << shamt) - 27'd1);
    if (diff > 8'd26) sy_d = {26'd0, |sig_y};
    else              sy_d = (sig_y >> shamt) | {26'd0, |lost};
  end

  // Add/subtract magnitudes; X >= Y so the difference is never negative
  logic [27:0] sum_d;
  always_comb begin
    if (x_sign_q != y_sign_q) sum_d = {1'b0, sx_q} - {1'b0, sy_q};
    else                      sum_d = {1'b0, sx_q} + {1'b0, sy_q};
  end

  // Normalise: carry-out shifts right, otherwise shift left by leading-zero count
  logic [4:0]  lzc;
  logic [26:0] nsig_d;
  logic signed [9:0] nexp_d;
  always_comb begin
    lzc = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sum_q[i]) lzc = 5'(26 - i);
    end
    if (sum_q[27]) begin
      nsig_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
      nexp_d = $signed({2'b00, x_exp_q}) + 10'sd1;
    end else begin
      nsig_d = sum_q[26:0] << lzc;
      nexp_d = $signed({2'b00, x_exp_q}) - $signed({5'd0, lzc});
    end
  end

  // Round, then range-check the exponent and merge special-case results
  logic        mcarry, is_zero;
  logic [22:0] rfrac;
  logic signed [9:0] rexp;
  logic [31:0] res_d;
  logic        ovf_d, unf_d;
`ifdef FPU_ROUND_NEAREST_EN
  logic        inc;
  logic [24:0] mant25;
`endif
  always_comb begin
`ifdef FPU_ROUND_NEAREST_EN
    inc    = nsig_q[2] & (nsig_q[1] | nsig_q[0] | nsig_q[3]);
    mant25 = {1'b0, nsig_q[26:3]} + {24'd0, inc};
    mcarry = mant25[24];
    rfrac  = mcarry ? mant25[23:1] : mant25[22:0];
`else
    mcarry = 1'b0;
    rfrac  = nsig_q[25:3];
`endif
    is_zero = ~(|nsig_q);
    rexp    = nexp_q + $signed({9'd0, mcarry});
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (spec_q) begin
      res_d = spec_res_q;
    end else if (is_zero) begin
      // Exact zero: sign is the AND of the effective signs (+0 on cancellation)
      res_d = {x_sign_q & y_sign_q, 31'd0};
    end else if (rexp >= 10'sd255) begin
      res_d = {x_sign_q, 8'hFF, 23'd0};
      ovf_d = 1'b1;
    end else if (rexp <= 10'sd0) begin
      res_d = {x_sign_q, 31'd0};
      unf_d = 1'b1;
    end else begin
      res_d = {x_sign_q, rexp[7:0], rfrac};
    end
  end

  // Datapath registers, each loaded in the state that produces them
  always_ff @(posedge clk) begin
    if (state_q == StIdle && start) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
    end
    if (state_q == StUnpack) begin
      x_sign_q   <= swap ? sb : sa;
      x_exp_q    <= swap ? eb : ea;
      x_man_q    <= swap ? mb : ma;
      y_sign_q   <= swap ? sa : sb;
      y_exp_q    <= swap ? ea : eb;
      y_man_q    <= swap ? ma : mb;
      spec_q     <= spec_d;
      spec_inv_q <= spec_inv_d;
      spec_res_q <= spec_res_d;
    end
    if (state_q == StAlign) begin
      sx_q <= sig_x;
      sy_q <= sy_d;
    end
    if (state_q == StAdd) sum_q <= sum_d;
    if (state_q == StNorm) begin
      nsig_q <= nsig_d;
      nexp_q <= nexp_d;
    end
  end

  // Output registers: result and flags held until the next done, flags cleared on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q   <= 1'b0;
      result_q <= 32'd0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == StIdle && start) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
        inv_q <= 1'b0;
      end
      if (state_q == StRound) begin
        done_q   <= 1'b1;
        result_q <= res_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
        inv_q    <= spec_q & spec_inv_q;
      end
    end
  end

  assign busy      = (state_q != StIdle) | done_q;
  assign done      = done_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign invalid   = inv_q;

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Directed self-checking bench for fpu_addsub_seq; expectations follow FPU_ROUND_NEAREST_EN.
module tb_fpu_addsub_seq;

  logic        clk = 1'b0;
  logic        reset, start, op;
  logic [31:0] a, b;
  logic        busy, done, overflow, underflow, invalid;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

`ifdef FPU_ROUND_NEAREST_EN
  localparam logic [31:0] ExpRnd1 = 32'h402CCCCD;
  localparam logic [31:0] ExpRnd2 = 32'h3F800001;
`else
  localparam logic [31:0] ExpRnd1 = 32'h402CCCCC;
  localparam logic [31:0] ExpRnd2 = 32'h3F800000;
`endif

  fpu_addsub_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (done) done_cnt++;
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic opv, input logic [31:0] exp_res, input logic [31:0] mask,
                        input logic [2:0] exp_flg);
    int cyc;
    @(negedge clk);
    a = av; b = bv; op = opv; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check_eq({tag, "_flgclr"}, {29'd0, overflow, underflow, invalid}, 32'd0);
    cyc = 0;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq({tag, "_lat"}, 32'(cyc), 32'd5);
    check_eq({tag, "_res"}, result & mask, exp_res & mask);
    check_eq({tag, "_flg"}, {29'd0, overflow, underflow, invalid}, {29'd0, exp_flg});
    tick();
    check_eq({tag, "_end"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) tick();
    reset = 1'b0;
    check_eq("rst_ctl", {27'd0, busy, done, overflow, underflow, invalid}, 32'd0);
    check_eq("rst_res", result, 32'd0);

    // Flags order: {overflow, underflow, invalid}
    run_op("add",     32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 32'hFFFFFFFF, 3'b000);
    run_op("rnd1",    32'h40000000, 32'h3F333333, 1'b0, ExpRnd1,      32'hFFFFFFFF, 3'b000);
    run_op("cancel",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 32'hFFFFFFFF, 3'b000);
    run_op("rnd2",    32'h3F800000, 32'h33C00000, 1'b0, ExpRnd2,      32'hFFFFFFFF, 3'b000);
    run_op("sub",     32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 32'hFFFFFFFF, 3'b000);
    run_op("infinf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 32'hFFFFFFFF, 3'b001);
    run_op("nan",     32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 32'hFFFFFFFF, 3'b001);
    run_op("inffin",  32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 32'hFFFFFFFF, 3'b000);
    run_op("ovf",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 32'hFFFFFFFF, 3'b100);
    run_op("unf_pos", 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 32'hFFFFFFFF, 3'b010);
    run_op("unf_neg", 32'h00800000, 32'h00800001, 1'b1, 32'h00000000, 32'h7FFFFFFF, 3'b010);
    run_op("nzero",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 32'hFFFFFFFF, 3'b000);
    run_op("nzsub",   32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 32'hFFFFFFFF, 3'b000);
    run_op("ftz",     32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 32'hFFFFFFFF, 3'b000);

    // start pulses at E2 and E5 must be ignored
    @(negedge clk);
    a = 32'h3FC00000; b = 32'h40100000; op = 1'b0; start = 1'b1; done_cnt = 0;
    tick();                                  // E0
    start = 1'b0;
    tick();                                  // E1
    a = 32'h3F800000; b = 32'h3F800000; op = 1'b1; start = 1'b1;
    tick();                                  // E2
    start = 1'b0;
    tick(); tick();                          // E3, E4
    start = 1'b1;
    tick();                                  // E5
    start = 1'b0;
    check_eq("hs_done_e5", {31'd0, done}, 32'd1);
    check_eq("hs_res", result, 32'h40700000);
    repeat (12) tick();
    check_eq("hs_one_done", 32'(done_cnt), 32'd1);
    check_eq("hs_hold", result, 32'h40700000);

    // start sampled at E6 is accepted; done at E11
    @(negedge clk);
    a = 32'h40000000; b = 32'h3F333333; op = 1'b0; start = 1'b1;
    tick();                                  // E0
    start = 1'b0;
    repeat (5) tick();                       // E1..E5
    check_eq("b2b_done1", {31'd0, done}, 32'd1);
    check_eq("b2b_res1", result, ExpRnd1);
    a = 32'h40400000; b = 32'h3F800000; op = 1'b1; start = 1'b1;
    tick();                                  // E6
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq("b2b_lat", 32'(cyc), 32'd5);
    check_eq("b2b_res2", result, 32'h40000000);

    // Reset at E3 aborts the operation
    tick();
    @(negedge clk);
    a = 32'h7F7FFFFF; b = 32'h7F7FFFFF; op = 1'b0; start = 1'b1;
    tick();                                  // E0
    start = 1'b0;
    tick(); tick();                          // E1, E2
    reset = 1'b1; done_cnt = 0;
    tick();                                  // E3
    reset = 1'b0;
    check_eq("abort_ctl", {27'd0, busy, done, overflow, underflow, invalid}, 32'd0);
    check_eq("abort_res", result, 32'd0);
    repeat (10) tick();
    check_eq("abort_nodone", 32'(done_cnt), 32'd0);

    // Reset wins over a simultaneous start
    @(negedge clk);
    a = 32'h3FC00000; b = 32'h40100000; op = 1'b0; start = 1'b1; reset = 1'b1; done_cnt = 0;
    tick();
    start = 1'b0; reset = 1'b0;
    check_eq("rst_win_busy", {31'd0, busy}, 32'd0);
    repeat (8) tick();
    check_eq("rst_win_nodone", 32'(done_cnt), 32'd0);

    run_op("post_rst", 32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 32'hFFFFFFFF, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
